// File: rtl/melody_pkg.sv
// melody_pkg: shared widths, sequencer state encoding and the default song table
package melody_pkg;
  localparam int ENTRY_W = 36;
  localparam int DIV_W = 28;
  localparam int DUR_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  typedef logic [15:0][ENTRY_W-1:0] song_t;
  // {div, dur}: div in clock_in cycles per tone period (50 MHz), dur in 50 ms ticks, dur 0 ends the song
  function automatic logic [ENTRY_W-1:0] default_entry(input logic [3:0] idx);
    case (idx)
      4'd0: return {28'd95556, 8'd4};
      4'd1: return {28'd75843, 8'd4};
      4'd2: return {28'd63776, 8'd4};
      4'd3: return {28'd0, 8'd2};
      4'd4: return {28'd47778, 8'd8};
      default: return '0;
    endcase
  endfunction
  function automatic song_t default_song();
    song_t s;
    for (int i = 0; i < 16; i++) s[i] = default_entry(4'(i));
    return s;
  endfunction
endpackage

// File: rtl/tone_div.sv
// tone_div: runtime-programmable square-wave divider, period div, high for floor(div/2) cycles
module tone_div import melody_pkg::*; (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             mute,
  input  logic [DIV_W-1:0] div,
  output logic             wave
);
  logic [DIV_W-1:0] cnt;
  // Counter wraps at div-1; the wave is a registered compare so it trails the counter by one cycle
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      wave <= 1'b0;
    end else begin
      cnt <= (clr || (en && cnt >= div - 1'b1)) ? '0 : en ? cnt + 1'b1 : cnt;
      wave <= en && !mute && cnt < (div >> 1);
    end
endmodule

// File: rtl/melody_player.sv
// melody_player: steps through a song table, playing each tone for dur ticks followed by a one-tick gap
module melody_player import melody_pkg::*; #(
  parameter logic [27:0] TICK_DIV = 28'd2_500_000,
  parameter int          NOTES = 16,
  parameter logic        LOOP = 1'b0,
  parameter song_t       SONG = default_song()
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       play,
  input  logic       stop,
  input  logic       mute,
  output logic       clock_out,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);
  state_t state;
  logic [DIV_W-1:0] div, tick_cnt;
  logic [DUR_W-1:0] dur, dur_cnt;
  logic [ENTRY_W-1:0] entry;
  logic play_q, armed, rise, tick, play_end, last_note, tone_en;
  assign entry = SONG[note_idx];
  assign rise = play && !play_q && armed;
  assign tick = tick_cnt == TICK_DIV - 1'b1;
  assign play_end = state == PLAY && tick && dur_cnt == dur - 1'b1;
  assign last_note = note_idx == 4'(NOTES - 1);
  assign tone_en = state == PLAY && !play_end && !stop;
  // Play-edge detector; armed stays low until play is seen low, so a level held through reset never starts a song
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      play_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      play_q <= play;
      armed <= armed || !play;
    end
  // Sequencer with tick prescaler (wraps every tick in PLAY/GAP) and per-note duration counter
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      note_idx <= '0;
      div <= '0;
      dur <= '0;
      tick_cnt <= '0;
      dur_cnt <= '0;
    end else begin
      done <= 1'b0;
      tick_cnt <= (state inside {PLAY, GAP} && !tick) ? tick_cnt + 1'b1 : '0;
      if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
      end else case (state)
        IDLE: if (rise) begin
          state <= LOAD;
          busy <= 1'b1;
          note_idx <= '0;
        end
        LOAD: begin
          div <= entry[ENTRY_W-1 -: DIV_W];
          dur <= entry[DUR_W-1:0];
          dur_cnt <= '0;
          if (entry[DUR_W-1:0] != '0) state <= PLAY;
          else if (LOOP) note_idx <= '0;
          else begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        PLAY: if (tick) begin
          dur_cnt <= dur_cnt + 1'b1;
          if (play_end) state <= GAP;
        end
        GAP: if (tick) begin
          if (!last_note || LOOP) begin
            note_idx <= last_note ? '0 : note_idx + 1'b1;
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  tone_div u_tone (
    .clock_in(clock_in),
    .reset_n(reset_n),
    .clr(state == LOAD),
    .en(tone_en),
    .mute(mute),
    .div(div),
    .wave(clock_out)
  );
endmodule
